puf_challenge_sequencer: RTL and testbench

PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

---
 rtl/puf_challenge_sequencer.sv | 98 +++++++++
 tb/tb_puf_challenge_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: drives challenges into a serial PUF, hands each response to a host, optional sweep to 8'hFF.
// Ports: clk/reset (sync, active-high); start, sweep_mode, challenge_in from host; puf_done, puf_response from PUF;
//        host_ack from host; puf_enables, puf_challenge, puf_ack to PUF; resp_valid, resp_data, resp_challenge to host;
//        busy, timeout_err, run_done status. All outputs registered.
module puf_challenge_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sweep_mode,
  input  logic [7:0]  challenge_in,
  input  logic        puf_done,
  input  logic [7:0]  puf_response,
  input  logic        host_ack,
  output logic [31:0] puf_enables,
  output logic [7:0]  puf_challenge,
  output logic        puf_ack,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic [7:0]  resp_challenge,
  output logic        busy,
  output logic        timeout_err,
  output logic        run_done
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ARM, EVAL, PRESENT, CLEAR, FINISH} state_t;
  state_t state, state_n;
  logic [7:0] cur, cur_n, resp_data_n, resp_challenge_n;
  logic sweep, sweep_n, timeout_err_n, expired;
  logic [CW-1:0] cnt, cnt_n;
  always_comb begin
    state_n = state;
    cur_n = cur;
    sweep_n = sweep;
    resp_data_n = resp_data;
    resp_challenge_n = resp_challenge;
    timeout_err_n = timeout_err;
    // only EVAL and CLEAR count; every other state parks the counter at 0 so each entry starts fresh
    cnt_n = (state == EVAL || state == CLEAR) ? cnt + 1'b1 : '0;
    // cnt holds the number of cycles already spent, so this is the last allowed cycle
    expired = cnt == CW'(TIMEOUT_CYCLES - 1);
    case (state)
      IDLE: if (start) begin
        cur_n = challenge_in;
        sweep_n = sweep_mode;
        timeout_err_n = 1'b0;
        state_n = ARM;
      end
      ARM: state_n = EVAL;
      EVAL: if (puf_done || expired) begin
        resp_data_n = puf_done ? puf_response : 8'h00;
        resp_challenge_n = cur;
        timeout_err_n = timeout_err | ~puf_done;
        state_n = PRESENT;
      end
      PRESENT: state_n = host_ack ? CLEAR : PRESENT;
      CLEAR: if (!puf_done || expired) begin
        timeout_err_n = timeout_err | puf_done;
        cur_n = (sweep && cur != 8'hFF) ? cur + 8'd1 : cur;
        state_n = (sweep && cur != 8'hFF) ? ARM : FINISH;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      sweep <= 1'b0;
      cnt <= '0;
      puf_enables <= '0;
      puf_challenge <= '0;
      puf_ack <= 1'b0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_challenge <= '0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      run_done <= 1'b0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      sweep <= sweep_n;
      cnt <= cnt_n;
      puf_enables <= {32{state_n == EVAL || state_n == PRESENT}};
      puf_challenge <= cur_n;
      puf_ack <= state_n == CLEAR;
      resp_valid <= state_n == PRESENT;
      resp_data <= resp_data_n;
      resp_challenge <= resp_challenge_n;
      busy <= state_n != IDLE;
      timeout_err <= timeout_err_n;
      run_done <= state_n == FINISH;
    end
  end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb_puf_challenge_sequencer: directed self-checking bench for puf_challenge_sequencer (TIMEOUT_CYCLES=16).
module tb_puf_challenge_sequencer;
  logic clk = 1'b0, reset, start, sweep_mode, puf_done, host_ack;
  logic [7:0] challenge_in, puf_response;
  logic [31:0] puf_enables;
  logic [7:0] puf_challenge, resp_data, resp_challenge;
  logic puf_ack, resp_valid, busy, timeout_err, run_done;
  int checks = 0, failures = 0, rd_cnt = 0;
  logic stable;
  puf_challenge_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .sweep_mode(sweep_mode), .challenge_in(challenge_in),
    .puf_done(puf_done), .puf_response(puf_response), .host_ack(host_ack),
    .puf_enables(puf_enables), .puf_challenge(puf_challenge), .puf_ack(puf_ack),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_challenge(resp_challenge),
    .busy(busy), .timeout_err(timeout_err), .run_done(run_done)
  );
  always #5 clk = ~clk;
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task step;
    @(posedge clk);
    @(negedge clk);
    if (run_done) rd_cnt++;
  endtask
  task chk_reset(input string tag);
    check({tag, "_en"}, puf_enables, 0);
    check({tag, "_ch"}, {24'd0, puf_challenge}, 0);
    check({tag, "_ack"}, {31'd0, puf_ack}, 0);
    check({tag, "_valid"}, {31'd0, resp_valid}, 0);
    check({tag, "_data"}, {24'd0, resp_data}, 0);
    check({tag, "_rch"}, {24'd0, resp_challenge}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_terr"}, {31'd0, timeout_err}, 0);
    check({tag, "_done"}, {31'd0, run_done}, 0);
  endtask
  task wait_eval(input string tag);
    int n;
    n = 0;
    while (puf_enables !== 32'hFFFF_FFFF && n < 100) begin
      step;
      n++;
    end
    check({tag, "_eval_reached"}, {31'd0, n < 100}, 1);
  endtask
  task serve(input logic [7:0] ch, input logic [7:0] resp, input string tag);
    wait_eval(tag);
    puf_done = 1'b1;
    puf_response = resp;
    step;
    check({tag, "_valid"}, {31'd0, resp_valid}, 1);
    check({tag, "_data"}, {24'd0, resp_data}, {24'd0, resp});
    check({tag, "_rch"}, {24'd0, resp_challenge}, {24'd0, ch});
    host_ack = 1'b1;
    step;
    host_ack = 1'b0;
    puf_done = 1'b0;
    check({tag, "_puf_ack"}, {31'd0, puf_ack}, 1);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    reset = 1; start = 0; sweep_mode = 0; challenge_in = 0; puf_done = 0; puf_response = 0; host_ack = 0;
    step;
    step;
    chk_reset("rst");
    reset = 0;
    step;
    challenge_in = 8'hA5; start = 1;
    step;
    start = 0;
    check("arm_busy", {31'd0, busy}, 1);
    check("arm_ch", {24'd0, puf_challenge}, 32'hA5);
    check("arm_en", puf_enables, 0);
    step;
    check("eval_en", puf_enables, 32'hFFFF_FFFF);
    repeat (9) step;
    check("eval_wait_valid", {31'd0, resp_valid}, 0);
    puf_done = 1; puf_response = 8'h3C;
    step;
    check("single_valid", {31'd0, resp_valid}, 1);
    check("single_data", {24'd0, resp_data}, 32'h3C);
    check("single_rch", {24'd0, resp_challenge}, 32'hA5);
    check("single_terr", {31'd0, timeout_err}, 0);
    check("present_en", puf_enables, 32'hFFFF_FFFF);
    host_ack = 1;
    step;
    host_ack = 0;
    check("clr_ack", {31'd0, puf_ack}, 1);
    check("clr_en", puf_enables, 0);
    check("clr_valid", {31'd0, resp_valid}, 0);
    step;
    step;
    check("clr_hold", {31'd0, puf_ack}, 1);
    puf_done = 0; rd_cnt = 0;
    step;
    check("fin_done", {31'd0, run_done}, 1);
    check("fin_ack", {31'd0, puf_ack}, 0);
    step;
    check("idle_done", {31'd0, run_done}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    check("single_rd_cnt", rd_cnt, 1);
    rd_cnt = 0; challenge_in = 8'hFC; sweep_mode = 1; start = 1;
    step;
    start = 0; sweep_mode = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] c;
      c = 8'hFC + 8'(i);
      serve(c, c ^ 8'h5A, "sweep");
    end
    step;
    check("sweep_fin", {31'd0, run_done}, 1);
    step;
    check("sweep_busy", {31'd0, busy}, 0);
    check("sweep_rd_cnt", rd_cnt, 1);
    check("sweep_nowrap", {24'd0, puf_challenge}, 32'hFF);
    challenge_in = 8'h11; start = 1;
    step;
    start = 0;
    step;
    repeat (15) step;
    check("to_not_yet", {31'd0, resp_valid}, 0);
    step;
    check("to_valid", {31'd0, resp_valid}, 1);
    check("to_data", {24'd0, resp_data}, 0);
    check("to_rch", {24'd0, resp_challenge}, 32'h11);
    check("to_terr", {31'd0, timeout_err}, 1);
    host_ack = 1;
    step;
    host_ack = 0;
    step;
    step;
    check("to_sticky", {31'd0, timeout_err}, 1);
    check("to_busy", {31'd0, busy}, 0);
    challenge_in = 8'h42; start = 1;
    step;
    start = 0;
    check("bp_terr_clr", {31'd0, timeout_err}, 0);
    wait_eval("bp");
    puf_done = 1; puf_response = 8'h99;
    step;
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      challenge_in = 8'h00; start = i[0]; puf_response = 8'(i);
      step;
      if (resp_valid !== 1 || resp_data !== 8'h99 || resp_challenge !== 8'h42 || busy !== 1) stable = 0;
    end
    start = 0;
    check("bp_stable", {31'd0, stable}, 1);
    host_ack = 1;
    step;
    host_ack = 0;
    check("clrto_ack", {31'd0, puf_ack}, 1);
    repeat (15) step;
    check("clrto_hold", {31'd0, puf_ack}, 1);
    check("clrto_terr0", {31'd0, timeout_err}, 0);
    step;
    check("clrto_fin", {31'd0, run_done}, 1);
    check("clrto_terr", {31'd0, timeout_err}, 1);
    step;
    step;
    check("bp_no_restart", {31'd0, busy}, 0);
    puf_done = 0;
    challenge_in = 8'h77; start = 1;
    step;
    start = 0;
    step;
    check("tie_eval", puf_enables, 32'hFFFF_FFFF);
    repeat (15) step;
    puf_done = 1; puf_response = 8'hC3;
    step;
    check("tie_valid", {31'd0, resp_valid}, 1);
    check("tie_data", {24'd0, resp_data}, 32'hC3);
    check("tie_rch", {24'd0, resp_challenge}, 32'h77);
    check("tie_terr", {31'd0, timeout_err}, 0);
    host_ack = 1;
    step;
    host_ack = 0; puf_done = 0;
    step;
    step;
    check("tie_busy", {31'd0, busy}, 0);
    challenge_in = 8'hF0; sweep_mode = 1; start = 1;
    step;
    start = 0; sweep_mode = 0;
    serve(8'hF0, 8'h11, "rs");
    step;
    step;
    check("rs_eval", puf_enables, 32'hFFFF_FFFF);
    check("rs_ch", {24'd0, puf_challenge}, 32'hF1);
    step;
    step;
    reset = 1; start = 1;
    step;
    chk_reset("mid");
    step;
    check("rst_prio_busy", {31'd0, busy}, 0);
    reset = 0; start = 0;
    step;
    check("post_rst_idle", {31'd0, busy}, 0);
    challenge_in = 8'h05; start = 1;
    step;
    start = 0;
    serve(8'h05, 8'hE7, "post");
    step;
    check("post_fin", {31'd0, run_done}, 1);
    step;
    check("post_busy", {31'd0, busy}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
